// File: rtl/ymux_rr.sv
// ymux_rr: N-channel W-bit valid/ready mux (fixed or round-robin select) into one output register; ports in_data/in_valid/in_ready, sel, mode, out_data/out_chan/out_valid/out_ready
module ymux_rr #(
  parameter int W = 2,
  parameter int N = 4,
  parameter int SELW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_chan,
  output logic              out_valid,
  input  logic              out_ready
);
  logic [SELW-1:0] ptr, gnt, ptr_nxt;
  logic            gv, load, xfer;
  always_comb begin
    int k;
    k = 0;
    gnt = sel;
    gv = 32'(sel) < N;
    if (mode) begin
      gnt = '0;
      gv = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
        k = int'(ptr) + i;
        k = k >= N ? k - N : k;
        if (in_valid[k]) begin
          gnt = SELW'(k);
          gv = 1'b1;
        end
      end
    end
  end
  assign load     = !out_valid || out_ready;
  assign in_ready = (gv && load && !reset) ? ({{(N-1){1'b0}}, 1'b1} << gnt) : '0;
  assign xfer     = |(in_valid & in_ready);
  assign ptr_nxt  = (32'(gnt) == N - 1) ? '0 : gnt + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= in_data[gnt*W +: W];
      out_chan  <= gnt;
      out_valid <= 1'b1;
      if (mode) ptr <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ymux_rr.sv
// tb_ymux_rr: randomized and directed check of ymux_rr against a spec-level reference model
module tb_ymux_rr;
  localparam int W = 2;
  localparam int N = 4;
  localparam int SELW = 2;
  logic            clk = 1'b0;
  logic            reset;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel;
  logic            mode;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;
  int tests = 0;
  int fails = 0;
  int m_ptr = 0;
  int m_data = 0;
  int m_chan = 0;
  int m_valid = 0;
  ymux_rr #(.W(W), .N(N), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int grant();
    int c;
    if (!mode) return (int'(sel) < N) ? int'(sel) : -1;
    for (int off = 0; off < N; off++) begin
      c = (m_ptr + off) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction
  task automatic step(input string tag);
    int g, exp_rdy;
    bit ld;
    #2;
    g  = grant();
    ld = (m_valid == 0) || out_ready;
    exp_rdy = (!reset && ld && g >= 0) ? (1 << g) : 0;
    check({tag, ".in_ready"}, int'(in_ready), exp_rdy);
    @(posedge clk);
    #1;
    if (reset) begin
      m_ptr = 0; m_data = 0; m_chan = 0; m_valid = 0;
    end else if (exp_rdy != 0 && in_valid[g]) begin
      m_data  = int'((in_data >> (g * W)) & ((1 << W) - 1));
      m_chan  = g;
      m_valid = 1;
      if (mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
    check({tag, ".out_valid"}, int'(out_valid), m_valid);
    check({tag, ".out_data"}, int'(out_data), m_data);
    check({tag, ".out_chan"}, int'(out_chan), m_chan);
  endtask
  initial begin
    reset = 1'b1; in_data = 8'he4; in_valid = 4'b1111; sel = 2'd0; mode = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    step("reset0");
    step("reset1");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step("rr_fair");
    check("rr_fair.last_chan", int'(out_chan), 3);
    mode = 1'b0; sel = 2'd2;
    for (int i = 0; i < 4; i++) step("fixed2");
    check("fixed2.data", int'(out_data), 2);
    reset = 1'b1;
    step("rst_sparse");
    reset = 1'b0; mode = 1'b1; in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) step("rr_sparse");
    in_valid = 4'b0000;
    for (int i = 0; i < 3; i++) step("rr_idle");
    in_valid = 4'b0010; mode = 1'b0; sel = 2'd1;
    step("bp_load");
    check("bp_load.data", int'(out_data), 1);
    out_ready = 1'b0; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'(1 << i) | 4'b1000;
      step("bp_hold");
    end
    in_valid = 4'b1111; out_ready = 1'b1;
    step("bp_release");
    step("rr_pre_rst");
    reset = 1'b1;
    step("rst_mid");
    reset = 1'b0; in_valid = 4'b0110;
    step("post_rst");
    check("post_rst.chan", int'(out_chan), 1);
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      in_data   = 8'($urandom);
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      mode      = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
